divisor_secuencial: RTL and testbench

//  Iterative signed integer divider, the inverse of the ALU multiplier, for the Execute-stage ALU.

---
 rtl/divisor_secuencial_if.sv | 25 ++
 rtl/divisor_secuencial.sv | 161 ++++++++++++++++
 tb/tb_divisor_secuencial.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/divisor_secuencial_if.sv
// Handshake and operand/result bundle between the Execute-stage ALU and the sequential divider.
interface divisor_secuencial_if #(
    parameter int n = 18
);
    logic         start;
    logic [n-1:0] A;
    logic [n-1:0] B;
    logic         busy;
    logic         done;
    logic [n-1:0] out;
    logic [n-1:0] rem;
    logic         overflow;
    logic         div_zero;
    logic         car;

    modport master (
        output start, A, B,
        input  busy, done, out, rem, overflow, div_zero, car
    );

    modport slave (
        input  start, A, B,
        output busy, done, out, rem, overflow, div_zero, car
    );
endinterface

// File: rtl/divisor_secuencial.sv
// Iterative signed restoring divider, one quotient bit per clock, start/busy/done handshake.
// Define DIVISOR_REM_EN to build the signed remainder output register; otherwise rem reads 0.
module divisor_secuencial #(
    parameter int n = 18
) (
    input logic                  clk,
    input logic                  rst,
    divisor_secuencial_if.slave  bus
);

    localparam int CntW = $clog2(n);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t            state_q, state_d;
    logic [n-1:0]      r_q, r_d;
    logic [n-1:0]      q_q, q_d;
    logic [n-1:0]      bmag_q, bmag_d;
    logic              sa_q, sa_d;
    logic              sb_q, sb_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [n-1:0]      out_q, out_d;
    logic              ovf_q, ovf_d;
    logic              dz_q, dz_d;
`ifdef DIVISOR_REM_EN
    logic [n-1:0]      rem_q, rem_d;
`endif

    logic [n-1:0]      abs_a, abs_b;
    logic              ovf_case;
    logic [n:0]        shift, diff;

    // |-2^(n-1)| wraps to 2^(n-1), which is exactly right as an unsigned magnitude.
    assign abs_a    = bus.A[n-1] ? -bus.A : bus.A;
    assign abs_b    = bus.B[n-1] ? -bus.B : bus.B;
    assign ovf_case = (bus.A == {1'b1, {(n-1){1'b0}}}) && (bus.B == {n{1'b1}});

    assign shift = {r_q, q_q[n-1]};
    assign diff  = shift - {1'b0, bmag_q};

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        bmag_d  = bmag_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        ovf_d   = ovf_q;
        dz_d    = dz_q;
`ifdef DIVISOR_REM_EN
        rem_d   = rem_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    sa_d   = bus.A[n-1];
                    sb_d   = bus.B[n-1];
                    bmag_d = abs_b;
                    q_d    = abs_a;
                    r_d    = '0;
                    cnt_d  = CntW'(n - 1);
                    if (bus.B == '0) begin
                        state_d = StDone;
                        out_d   = '1;
                        ovf_d   = 1'b0;
                        dz_d    = 1'b1;
`ifdef DIVISOR_REM_EN
                        rem_d   = bus.A;
`endif
                    end else if (ovf_case) begin
                        state_d = StDone;
                        out_d   = bus.A;
                        ovf_d   = 1'b1;
                        dz_d    = 1'b0;
`ifdef DIVISOR_REM_EN
                        rem_d   = '0;
`endif
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                // diff[n] is the borrow: set means the trial subtraction failed.
                if (!diff[n]) begin
                    r_d = diff[n-1:0];
                    q_d = {q_q[n-2:0], 1'b1};
                end else begin
                    r_d = shift[n-1:0];
                    q_d = {q_q[n-2:0], 1'b0};
                end
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == '0) begin
                    state_d = StDone;
                    out_d   = (sa_q ^ sb_q) ? -q_d : q_d;
                    ovf_d   = 1'b0;
                    dz_d    = 1'b0;
`ifdef DIVISOR_REM_EN
                    rem_d   = sa_q ? -r_d : r_d;
`endif
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            r_q     <= '0;
            q_q     <= '0;
            bmag_q  <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            cnt_q   <= '0;
            out_q   <= '0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            bmag_q  <= bmag_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            ovf_q   <= ovf_d;
            dz_q    <= dz_d;
        end
    end

`ifdef DIVISOR_REM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
        end else begin
            rem_q <= rem_d;
        end
    end

    assign bus.rem = rem_q;
`else
    assign bus.rem = '0;
`endif

    assign bus.busy     = (state_q == StRun);
    assign bus.done     = (state_q == StDone);
    assign bus.out      = out_q;
    assign bus.overflow = ovf_q;
    assign bus.div_zero = dz_q;
    assign bus.car      = 1'b0;

endmodule

// File: tb/tb_divisor_secuencial.sv
// Self-checking bench for divisor_secuencial: scoreboard of expected results checked on done.
module tb_divisor_secuencial;

    localparam int N = 18;

    logic clk = 1'b0;
    logic rst;

    divisor_secuencial_if #(.n(N)) bus ();

    divisor_secuencial #(.n(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         ovf;
        logic         dz;
        int           lat;
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic push_expect(input logic signed [N-1:0] a, input logic signed [N-1:0] b);
        exp_t e;
        int   ai;
        int   bi;
        ai = a;
        bi = b;
        if (bi == 0) begin
            e.q = '1; e.r = a; e.ovf = 1'b0; e.dz = 1'b1; e.lat = 1;
        end else if (ai == -(1 << (N - 1)) && bi == -1) begin
            e.q = a; e.r = '0; e.ovf = 1'b1; e.dz = 1'b0; e.lat = 1;
        end else begin
            e.q = N'(ai / bi); e.r = N'(ai % bi); e.ovf = 1'b0; e.dz = 1'b0; e.lat = N + 1;
        end
`ifndef DIVISOR_REM_EN
        e.r = '0;
`endif
        sb_q.push_back(e);
    endtask

    task automatic start_op(input logic signed [N-1:0] a, input logic signed [N-1:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        @(posedge clk);
        #1 bus.start = 1'b0;
        push_expect(a, b);
    endtask

    task automatic wait_check(input string name);
        exp_t e;
        int   cyc  = 0;
        bit   seen = 1'b0;
        e = sb_q.pop_front();
        while (cyc < N + 10 && !seen) begin
            @(negedge clk);
            cyc++;
            if (bus.done) seen = 1'b1;
        end
        vectors++;
        if (!seen || cyc != e.lat) begin
            miscompares++;
            $display("FAIL %s latency: got %0d (seen=%0b) expected %0d", name, cyc, seen, e.lat);
        end
        if (seen) begin
            vectors++;
            if (bus.out !== e.q) begin
                miscompares++;
                $display("FAIL %s out: got %0h expected %0h", name, bus.out, e.q);
            end
            vectors++;
            if (bus.rem !== e.r) begin
                miscompares++;
                $display("FAIL %s rem: got %0h expected %0h", name, bus.rem, e.r);
            end
            vectors++;
            if ({bus.overflow, bus.div_zero, bus.car, bus.busy} !== {e.ovf, e.dz, 2'b00}) begin
                miscompares++;
                $display("FAIL %s flags ovf/dz/car/busy: got %b expected %b", name,
                         {bus.overflow, bus.div_zero, bus.car, bus.busy}, {e.ovf, e.dz, 2'b00});
            end
            @(negedge clk);
            vectors++;
            if (bus.done !== 1'b0 || bus.out !== e.q) begin
                miscompares++;
                $display("FAIL %s pulse/hold: got done=%b out=%0h expected done=0 out=%0h",
                         name, bus.done, bus.out, e.q);
            end
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({bus.busy, bus.done, bus.out, bus.rem, bus.overflow, bus.div_zero, bus.car} !== '0)
        begin
            miscompares++;
            $display("FAIL reset: got busy=%b done=%b out=%0h rem=%0h ovf=%b dz=%b expected all 0",
                     bus.busy, bus.done, bus.out, bus.rem, bus.overflow, bus.div_zero);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        start_op(18'sd100, 18'sd7);
        wait_check("basic 100/7");
    endtask

    task automatic test_signs();
        start_op(-18'sd100, 18'sd7);
        wait_check("-100/7");
        start_op(18'sd100, -18'sd7);
        wait_check("100/-7");
        start_op(-18'sd100, -18'sd7);
        wait_check("-100/-7");
    endtask

    task automatic test_div_zero();
        start_op(18'sd12345, 18'sd0);
        wait_check("div_zero");
    endtask

    task automatic test_overflow();
        start_op(-18'sd131072, -18'sd1);
        wait_check("overflow");
        start_op(-18'sd131072, 18'sd1);
        wait_check("min/1");
    endtask

    task automatic test_back_to_back();
        logic signed [N-1:0] a;
        logic signed [N-1:0] b;
        for (int i = 0; i < 10; i++) begin
            a = N'($urandom);
            b = (i == 3) ? N'(0) : N'($urandom_range(0, 2000) - 1000);
            start_op(a, b);
            wait_check("random");
        end
    endtask

    task automatic test_busy_ignore();
        exp_t e;
        int   dones = 0;
        logic [N-1:0] got_out = '0;
        start_op(18'sd50, 18'sd5);
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 18'sd9;
        bus.B     = 18'sd3;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < N + 8; i++) begin
            @(negedge clk);
            if (bus.done) begin
                dones++;
                got_out = bus.out;
            end
        end
        e = sb_q.pop_front();
        vectors++;
        if (dones !== 1) begin
            miscompares++;
            $display("FAIL busy_ignore done count: got %0d expected 1", dones);
        end
        vectors++;
        if (got_out !== e.q) begin
            miscompares++;
            $display("FAIL busy_ignore out: got %0h expected %0h", got_out, e.q);
        end
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        start_op(18'sd50, 18'sd7);
        void'(sb_q.pop_back());
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({bus.busy, bus.done, bus.out, bus.rem, bus.overflow, bus.div_zero} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid clear: got busy=%b done=%b out=%0h rem=%0h expected all 0",
                     bus.busy, bus.done, bus.out, bus.rem);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N + 4; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        vectors++;
        if (dones !== 0) begin
            miscompares++;
            $display("FAIL reset_mid spurious done: got %0d expected 0", dones);
        end
        start_op(18'sd7, 18'sd2);
        wait_check("after reset 7/2");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_div_zero();
        test_overflow();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
